// File: rtl/lfsr_check_pkg.sv
// Shared types and the XNOR predictor for the 8-bit LFSR checker (taps 7,3,2,1).
package lfsr_check_pkg;

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_e;

  localparam logic [7:0] Taps = 8'b1000_1110;

  // Predicted next sequence bit for the current 8-bit history.
  function automatic logic lfsr8_next_bit(input logic [7:0] s);
    return ~(^(s & Taps));
  endfunction

endpackage

// File: rtl/lfsr_8bit_checker.sv
// Self-synchronising receive checker for the 8-bit XNOR LFSR sequence.
// Optional macro LFSR_CHECK_STATS_EN builds the accepted-LOCKED-beat counter on bit_cnt_o.
module lfsr_8bit_checker
  import lfsr_check_pkg::*;
#(
  parameter int LOCK_THRESH = 16,
  parameter int ERR_THRESH  = 4,
  parameter int WINDOW      = 64,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic                 valid_i,
  input  logic                 data_i,
  output logic                 ready_o,
  output logic                 locked_o,
  output logic                 err_o,
  output logic                 lock_lost_o,
  output logic [CNT_WIDTH-1:0] err_cnt_o,
  output logic [CNT_WIDTH-1:0] bit_cnt_o
);

  localparam int WinW = $clog2(WINDOW + 1);
  localparam int ErrW = $clog2(ERR_THRESH + 1);

  state_e               r_state;
  logic [7:0]           r_shift;
  logic [2:0]           r_fill;
  logic [7:0]           r_match;
  logic [WinW-1:0]      r_win_cnt;
  logic [ErrW-1:0]      r_win_err;
  logic [CNT_WIDTH-1:0] r_err_cnt;
  logic                 r_err;
  logic                 r_lock_lost;

  logic                 w_beat;
  logic                 w_exp;
  logic                 w_miss;
  logic [7:0]           w_shift_in;
  logic [WinW-1:0]      w_win_nxt;
  logic [ErrW-1:0]      w_werr_nxt;
  logic                 w_err_sat;

  assign ready_o    = en_i & ~clr_i;
  assign w_beat     = valid_i & ready_o;
  assign w_exp      = lfsr8_next_bit(r_shift);
  assign w_miss     = data_i ^ w_exp;
  assign w_shift_in = {r_shift[6:0], data_i};
  assign w_win_nxt  = r_win_cnt + WinW'(1);
  assign w_werr_nxt = r_win_err + ErrW'(w_miss);
  assign w_err_sat  = (r_err_cnt == {CNT_WIDTH{1'b1}});

  // Sequencer FSM, predictor history, window/error counters and output pulses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= SEED;
      r_shift     <= 8'h00;
      r_fill      <= 3'd0;
      r_match     <= 8'd0;
      r_win_cnt   <= {WinW{1'b0}};
      r_win_err   <= {ErrW{1'b0}};
      r_err_cnt   <= {CNT_WIDTH{1'b0}};
      r_err       <= 1'b0;
      r_lock_lost <= 1'b0;
    end else if (clr_i) begin
      r_state     <= SEED;
      r_shift     <= 8'h00;
      r_fill      <= 3'd0;
      r_match     <= 8'd0;
      r_win_cnt   <= {WinW{1'b0}};
      r_win_err   <= {ErrW{1'b0}};
      r_err_cnt   <= {CNT_WIDTH{1'b0}};
      r_err       <= 1'b0;
      r_lock_lost <= 1'b0;
    end else begin
      r_err       <= 1'b0;
      r_lock_lost <= 1'b0;
      if (w_beat) begin
        case (r_state)
          SEED: begin
            r_shift <= w_shift_in;
            if (r_fill == 3'd7) begin
              // All-ones is the XNOR lock-up state and can never come from a healthy generator.
              r_fill  <= 3'd0;
              r_match <= 8'd0;
              r_state <= (w_shift_in == 8'hFF) ? SEED : VERIFY;
            end else begin
              r_fill <= r_fill + 3'd1;
            end
          end
          VERIFY: begin
            r_shift <= w_shift_in;
            if (w_miss) begin
              r_state <= SEED;
              r_fill  <= 3'd0;
            end else if ((r_match + 8'd1) == 8'(LOCK_THRESH)) begin
              r_state   <= LOCKED;
              r_win_cnt <= {WinW{1'b0}};
              r_win_err <= {ErrW{1'b0}};
            end else begin
              r_match <= r_match + 8'd1;
            end
          end
          LOCKED: begin
            // Flywheel: the predictor feeds on its own output, so line errors never corrupt it.
            r_shift <= {r_shift[6:0], w_exp};
            r_err   <= w_miss;
            if (w_miss && !w_err_sat) begin
              r_err_cnt <= r_err_cnt + CNT_WIDTH'(1);
            end else begin
              r_err_cnt <= r_err_cnt;
            end
            if (w_werr_nxt == ErrW'(ERR_THRESH)) begin
              r_state     <= SEED;
              r_fill      <= 3'd0;
              r_lock_lost <= 1'b1;
            end else if (w_win_nxt == WinW'(WINDOW)) begin
              r_win_cnt <= {WinW{1'b0}};
              r_win_err <= {ErrW{1'b0}};
            end else begin
              r_win_cnt <= w_win_nxt;
              r_win_err <= w_werr_nxt;
            end
          end
          default: begin
            r_state <= SEED;
            r_fill  <= 3'd0;
          end
        endcase
      end else begin
        r_state <= r_state;
      end
    end
  end

  assign locked_o    = (r_state == LOCKED);
  assign err_o       = r_err;
  assign lock_lost_o = r_lock_lost;
  assign err_cnt_o   = r_err_cnt;

`ifdef LFSR_CHECK_STATS_EN
  logic [CNT_WIDTH-1:0] r_bit_cnt;

  // Saturating count of beats accepted while LOCKED, the BER denominator.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_bit_cnt <= {CNT_WIDTH{1'b0}};
    end else if (clr_i) begin
      r_bit_cnt <= {CNT_WIDTH{1'b0}};
    end else if (w_beat && (r_state == LOCKED) && (r_bit_cnt != {CNT_WIDTH{1'b1}})) begin
      r_bit_cnt <= r_bit_cnt + CNT_WIDTH'(1);
    end else begin
      r_bit_cnt <= r_bit_cnt;
    end
  end

  assign bit_cnt_o = r_bit_cnt;
`else
  assign bit_cnt_o = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_lfsr_8bit_checker.sv
// Scoreboard bench: randomized stimulus checked against a queue-based reference model.
module tb_lfsr_8bit_checker;

  localparam int LOCK_THRESH = 16;
  localparam int ERR_THRESH  = 4;
  localparam int WINDOW      = 64;
  localparam int CNT_WIDTH   = 4;
  localparam int CMAX        = (1 << CNT_WIDTH) - 1;

  logic clk, rst_i, clr_i, en_i, valid_i, data_i;
  logic ready_o, locked_o, err_o, lock_lost_o;
  logic [CNT_WIDTH-1:0] err_cnt_o, bit_cnt_o;

  lfsr_8bit_checker #(
    .LOCK_THRESH(LOCK_THRESH), .ERR_THRESH(ERR_THRESH),
    .WINDOW(WINDOW), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .clr_i(clr_i), .en_i(en_i),
    .valid_i(valid_i), .data_i(data_i), .ready_o(ready_o),
    .locked_o(locked_o), .err_o(err_o), .lock_lost_o(lock_lost_o),
    .err_cnt_o(err_cnt_o), .bit_cnt_o(bit_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int locked;
    int err;
    int lost;
    int errc;
    int bitc;
  } exp_t;

  exp_t sb_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int n_err_seen  = 0;
  int n_lost_seen = 0;

  // Reference model state (phase: 0 collecting seed, 1 confirming, 2 locked)
  int m_phase;
  int seed_q[$];
  int pred;
  int run;
  int win_flags[$];
  int m_errc, m_bitc;
  int gen_state;

  function automatic int ref_next(input int s);
    return 1 - ((((s >> 7) & 1) + ((s >> 3) & 1) + ((s >> 2) & 1) + ((s >> 1) & 1)) % 2);
  endfunction

  task automatic check(input string name, input int act, input int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    seed_q.delete();
    win_flags.delete();
    pred = 0;
    run = 0;
    m_errc = 0;
    m_bitc = 0;
  endtask

  task automatic model_beat(input int d, output int e_err, output int e_lost);
    int e, val, nerr;
    e_err = 0;
    e_lost = 0;
    if (m_phase == 0) begin
      seed_q.push_back(d);
      if (seed_q.size() == 8) begin
        val = 0;
        for (int i = 0; i < 8; i++) val = val * 2 + seed_q[i];
        seed_q.delete();
        if (val != 255) begin
          pred = val;
          run = 0;
          m_phase = 1;
        end
      end
    end else if (m_phase == 1) begin
      e = ref_next(pred);
      if (d != e) begin
        m_phase = 0;
      end else begin
        pred = ((pred << 1) | d) & 255;
        run++;
        if (run == LOCK_THRESH) begin
          m_phase = 2;
          win_flags.delete();
        end
      end
    end else begin
      e = ref_next(pred);
      pred = ((pred << 1) | e) & 255;
      if (m_bitc < CMAX) m_bitc++;
      if (d != e) begin
        e_err = 1;
        if (m_errc < CMAX) m_errc++;
      end
      win_flags.push_back(e_err);
      nerr = 0;
      foreach (win_flags[i]) nerr += win_flags[i];
      if (nerr >= ERR_THRESH) begin
        e_lost = 1;
        m_phase = 0;
      end else if (win_flags.size() == WINDOW) begin
        win_flags.delete();
      end
    end
  endtask

  // One clock of stimulus: drive at negedge, predict, push expectation, return after the edge
  task automatic step(input bit v, input bit e, input bit c, input bit d);
    exp_t x;
    int er, lo;
    @(negedge clk);
    valid_i = v; en_i = e; clr_i = c; data_i = d;
    #1;
    check("ready", int'(ready_o), int'(e & ~c));
    er = 0; lo = 0;
    if (c) model_reset();
    else if (v && e) model_beat(int'(d), er, lo);
    x.locked = (m_phase == 2) ? 1 : 0;
    x.err = er;
    x.lost = lo;
    x.errc = m_errc;
`ifdef LFSR_CHECK_STATS_EN
    x.bitc = m_bitc;
`else
    x.bitc = 0;
`endif
    sb_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic next_gen(output int b);
    b = ref_next(gen_state);
    gen_state = ((gen_state << 1) | b) & 255;
  endtask

  // Optional random idle cycles, then one accepted generator bit (optionally inverted)
  task automatic send(input bit flip, input bit gaps);
    int b, n;
    if (gaps) begin
      n = $urandom_range(2, 0);
      for (int i = 0; i < n; i++) begin
        if ($urandom % 2) step(1'b0, 1'($urandom % 2), 1'b0, 1'($urandom % 2));
        else step(1'b1, 1'b0, 1'b0, 1'($urandom % 2));
      end
    end
    next_gen(b);
    step(1'b1, 1'b1, 1'b0, 1'(b) ^ flip);
  endtask

  task automatic relock_check(input string tag, input bit gaps);
    for (int i = 1; i <= 24; i++) begin
      send(1'b0, gaps);
      if (i == 23) check({tag, "_not_yet_locked"}, int'(locked_o), 0);
      if (i == 24) check({tag, "_locked_at_24"}, int'(locked_o), 1);
    end
  endtask

  // Monitor: every registered response is compared with the oldest queued expectation
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #2;
      if (sb_q.size() > 0) begin
        x = sb_q.pop_front();
        check("locked", int'(locked_o), x.locked);
        check("err", int'(err_o), x.err);
        check("lock_lost", int'(lock_lost_o), x.lost);
        check("err_cnt", int'(err_cnt_o), x.errc);
        check("bit_cnt", int'(bit_cnt_o), x.bitc);
        if (err_o) n_err_seen++;
        if (lock_lost_o) n_lost_seen++;
      end
    end
  end

  initial begin
    int b, e0, l0;
    rst_i = 1'b1; clr_i = 1'b0; en_i = 1'b0; valid_i = 1'b0; data_i = 1'b0;
    gen_state = 0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_i = 1'b0;

    // Reset state
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("rst_locked", int'(locked_o), 0);
    check("rst_err_cnt", int'(err_cnt_o), 0);

    // 1: continuous clean sequence from seed 0; lock one cycle after beat 24
    relock_check("t1", 1'b0);
    for (int i = 0; i < 976; i++) send(1'b0, 1'b0);
    check("t1_err_cnt", int'(err_cnt_o), 0);
    check("t1_err_pulses", n_err_seen, 0);

    // 2: three isolated errors, 10 beats apart
    e0 = n_err_seen;
    for (int k = 0; k < 3; k++) begin
      send(1'b1, 1'b1);
      for (int i = 0; i < 9; i++) send(1'b0, 1'b1);
    end
    check("t2_err_pulses", n_err_seen - e0, 3);
    check("t2_err_cnt", int'(err_cnt_o), 3);
    check("t2_locked", int'(locked_o), 1);
    for (int i = 0; i < 100; i++) send(1'b0, 1'b1);
    check("t2_err_cnt_after", int'(err_cnt_o), 3);

    // 3: four consecutive errors lose lock; relock 24 beats later
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("t3_clr_err_cnt", int'(err_cnt_o), 0);
    relock_check("t3a", 1'b0);
    l0 = n_lost_seen;
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 1'b0);
      if (i == 2) check("t3_still_locked", int'(locked_o), 1);
    end
    check("t3_lock_lost_pulse", int'(lock_lost_o), 1);
    check("t3_unlocked", int'(locked_o), 0);
    check("t3_err_cnt_kept", int'(err_cnt_o), 4);
    relock_check("t3b", 1'b0);
    check("t3_lost_count", n_lost_seen - l0, 1);

    // 4: all-ones seed must be rejected
    step(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
    check("t4_ff_unlocked", int'(locked_o), 0);
    relock_check("t4", 1'b0);

    // 5: random valid/en toggling, then clr in the middle of VERIFY
    step(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 300; i++) begin
      bit v, e;
      v = 1'($urandom % 2);
      e = 1'(($urandom % 4) != 0);
      if (v && e) begin
        next_gen(b);
        step(1'b1, 1'b1, 1'b0, 1'(b));
      end else begin
        step(v, e, 1'b0, 1'($urandom % 2));
      end
    end
    step(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) send(1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'($urandom % 2), 1'b0, 1'b0, 1'($urandom % 2));
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check("t5_clr_locked", int'(locked_o), 0);
    check("t5_clr_err", int'(err_o), 0);
    check("t5_clr_lost", int'(lock_lost_o), 0);
    check("t5_clr_err_cnt", int'(err_cnt_o), 0);
    check("t5_clr_bit_cnt", int'(bit_cnt_o), 0);
    relock_check("t5", 1'b1);

    // 6: 20 errors spaced 30 beats apart saturate the 4-bit counters without losing lock
    for (int k = 0; k < 20; k++) begin
      send(1'b1, 1'b0);
      for (int i = 0; i < 29; i++) send(1'b0, 1'b0);
    end
    check("t6_err_cnt_sat", int'(err_cnt_o), 15);
    check("t6_locked", int'(locked_o), 1);
`ifdef LFSR_CHECK_STATS_EN
    check("t6_bit_cnt_sat", int'(bit_cnt_o), 15);
`else
    check("t6_bit_cnt_zero", int'(bit_cnt_o), 0);
`endif

    repeat (3) @(posedge clk);
    #3;
    check("scoreboard_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
